core_seq_ctrl: RTL and testbench
================================

# core_seq_ctrl

Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the instruction-register, PC and register-file write strobes and the PC source select. It takes the instruction decoder's control outputs and runs the valid/ack handshakes to instruction and data memory. It sits between the decoder, the PC/IR registers, the register file and the memory ports in the core top.

## Interface
- `RESET_PC`, 32'h8000_0000: PC value the top loads on reset; the controller only forwards it via `pc_sel`.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `inst`  in  32  current IR contents, used for opcode, EBREAK and illegal detection.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jal`, `jalr`  in  1 each  decoder control outputs, valid from DECODE onward.
- `branch_taken`  in  1  comparator result, valid in EXEC.
- `imem_ack`  in  1  instruction read data valid this cycle.
- `dmem_ack`  in  1  data access complete this cycle; load data valid.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  latch instruction memory data into IR.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data access is a store.
- `pc_we`  out  1  update PC.
- `pc_sel`  out  2  PC source: 00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result & ~1 (JALR), 11 RESET_PC.
- `rf_we`  out  1  register-file write strobe.
- `halted`  out  1  core stopped.
- `trap`  out  1  illegal instruction seen.
- `state`  out  3  current FSM state, for debug.
- `instret`  out  32  count of retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. All other encodings go to FETCH.
- FETCH: `imem_req`=1 until `imem_ack`. On ack: `ir_we`=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, then EXEC. If `inst`==32'h0010_0073 (EBREAK), go to HALT instead.
- EXEC:
  - `mem_read` or `mem_write`: go to MEM.
  - `branch`: `pc_we`=1, `pc_sel`=01 if `branch_taken` else 00; retire; go to FETCH.
  - `jal`/`jalr`: go to WB.
  - Otherwise, with `reg_write`: go to WB.
  - Otherwise (FENCE, SYSTEM non-EBREAK): `pc_we`=1, `pc_sel`=00; retire; go to FETCH.
- MEM: `dmem_req`=1 and `dmem_we`=`mem_write`, held until `dmem_ack`.
  - On ack for a load: go to WB.
  - On ack for a store: `pc_we`=1, `pc_sel`=00; retire; go to FETCH.
- WB: `rf_we`=`reg_write`, `pc_we`=1, `pc_sel`=01 for JAL, 10 for JALR, else 00; retire; go to FETCH.
- Retire: `instret` increments by 1 in that cycle and wraps from 32'hFFFF_FFFF to 0.
- HALT: absorbing. All strobes are 0 and `halted`=1. Only `rst` exits.
- Strobes are single-cycle, decoded combinationally from state and inputs.

## Timing
- Reset: on the first edge with `rst`=1, state←FETCH and `instret`←0. While `rst`=1: `pc_we`=1, `pc_sel`=11, and every other output is 0 (`state`=0, `halted`=0, `trap`=0).
- Zero-wait memory latencies: ALU/LUI/AUIPC/JAL/JALR 4 cycles; load 5; store 4; branch 3.
- Each wait cycle on `imem_ack`/`dmem_ack` adds exactly one cycle.
- Acks are sampled only while the matching request is high. Acks with no request are ignored.
- A request drops in the cycle after its ack and is never re-asserted for the same access.
- `rst` mid-access abandons the outstanding request; the memory side must tolerate this. Ack arriving during or after reset is ignored.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - In DECODE, an opcode outside the RV32I set (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM) → HALT with `trap`=1 and `halted`=1.
  - `trap` is sticky until reset.
- Not defined: illegal opcodes execute as NOPs (PC+4, no writes, retired). `trap` is tied to 0.

## Structure
- Shared `core_pkg` holds:
  - state encoding enum;
  - `pc_sel` constants PCS_PC4, PCS_IMM, PCS_JALR, PCS_RST;
  - RV32I opcode localparams, shared with the decoder;
  - EBREAK encoding.
- No sub-module: a single FSM with a registered state and `instret`, plus combinational output decode.

## Test plan
- Reset then ADDI x1,x0,5 with 0-wait memory → `imem_req` at cycle 0, `ir_we` at cycle 0, `rf_we`+`pc_we`(sel 00) at cycle 3, `instret`=1.
- LW with `dmem_ack` delayed 2 cycles → `dmem_req` held 3 cycles with `dmem_we`=0, `rf_we` one cycle after ack, 7 total cycles.
- BEQ with `branch_taken`=1, then `branch_taken`=0 → `pc_sel`=01, then 00, at cycle 2; `rf_we` never asserted.
- JALR → in WB `rf_we`=1, `pc_sel`=10; SW → `dmem_we`=1, `pc_we` on ack, `rf_we`=0.
- EBREAK (32'h0010_0073) → HALT at cycle 2, `halted`=1 for 100 cycles, no requests; then `rst` → FETCH.
- Opcode 7'b1111111, macro on → `trap`=1, `halted`=1; macro off → retired as NOP, `instret`+1. Plus `rst` asserted mid-MEM → `dmem_req`=0 next cycle, later ack ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: sequencer states,
// PC source selects, opcodes and the EBREAK word.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam logic [1:0] PCS_PC4  = 2'b00;
  localparam logic [1:0] PCS_IMM  = 2'b01;
  localparam logic [1:0] PCS_JALR = 2'b10;
  localparam logic [1:0] PCS_RST  = 2'b11;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  function automatic logic is_rv32i(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OPIMM, OPC_OP, OPC_FENCE,
      OPC_SYSTEM: is_rv32i = 1'b1;
      default:    is_rv32i = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Optional: ILLEGAL_TRAP_EN halts with a sticky trap.
module core_seq_ctrl
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic        halted,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] instret_q;
  logic        retire;
  logic        legal;
  logic        trap_set;

  assign legal = is_rv32i(inst[6:0]);

  // Next state and single-cycle strobes from state and inputs
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PCS_PC4;
    rf_we    = 1'b0;
    halted   = 1'b0;
    retire   = 1'b0;
    trap_set = 1'b0;
    if (rst) begin
      pc_we   = 1'b1;
      pc_sel  = PCS_RST;
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (inst == INST_EBREAK) begin
            state_d = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
          end else if (!legal) begin
            trap_set = 1'b1;
            state_d  = ST_HALT;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Unknown opcodes fall through as PC+4 NOPs
          if (!legal) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else if (mem_read || mem_write) begin
            state_d = ST_MEM;
          end else if (branch) begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PCS_IMM : PCS_PC4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else if (jal || jalr || reg_write) begin
            state_d = ST_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = mem_write;
          if (dmem_ack) begin
            if (mem_write) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          rf_we   = reg_write;
          pc_we   = 1'b1;
          pc_sel  = jal  ? PCS_IMM  :
                    jalr ? PCS_JALR : PCS_PC4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // State register and wrapping retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;

  // Sticky illegal-instruction flag
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else if (trap_set) trap_q <= 1'b1;
  end

  assign trap = trap_q & ~rst;
`else
  assign trap = 1'b0;
`endif

  assign state   = rst ? 3'd0  : state_q;
  assign instret = rst ? '0    : instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: vector table
// plus halt, illegal-opcode and mid-access reset runs.
module tb_core_seq_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        reg_write, mem_read, mem_write;
  logic        branch, jal, jalr, branch_taken;
  logic        imem_ack, dmem_ack;
  logic        imem_req, ir_we, dmem_req, dmem_we;
  logic        pc_we, rf_we, halted, trap;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int exp_instret = 0;

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst),
    .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch),
    .jal(jal), .jalr(jalr),
    .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .halted(halted), .trap(trap), .state(state),
    .instret(instret)
  );

  typedef struct {
    logic [31:0] inst;
    logic        rw, mr, mw, br, bt, jl, jr;
    logic        spur;
    int          iw, dw;
    int          cyc, rf;
    logic [1:0]  sel;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] i,
    input logic rw, mr, mw, br, bt, jl, jr, sp,
    input int iw, dw, cyc, rf,
    input logic [1:0] sel);
    vec_t v;
    v.inst = i; v.rw = rw; v.mr = mr; v.mw = mw;
    v.br = br; v.bt = bt; v.jl = jl; v.jr = jr;
    v.spur = sp; v.iw = iw; v.dw = dw;
    v.cyc = cyc; v.rf = rf; v.sel = sel;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int icnt = 0, dcnt = 0;
    int nir = 0, nireq = 0, ndreq = 0;
    int ndwe = 0, nrf = 0, cyc = -1;
    int edreq, edwe;
    logic [1:0] sel = 2'b00;
    bit done = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    inst = v.inst; reg_write = v.rw;
    mem_read = v.mr; mem_write = v.mw;
    branch = v.br; branch_taken = v.bt;
    jal = v.jl; jalr = v.jr;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      imem_ack = imem_req ? (icnt == v.iw) : v.spur;
      dmem_ack = dmem_req ? (dcnt == v.dw) : v.spur;
      if (imem_req) icnt++;
      if (dmem_req) dcnt++;
      #1;
      nir   += int'(ir_we);
      nireq += int'(imem_req);
      ndreq += int'(dmem_req);
      ndwe  += int'(dmem_req & dmem_we);
      nrf   += int'(rf_we);
      if (pc_we) begin
        done = 1;
        cyc  = c + 1;
        sel  = pc_sel;
      end
    end
    edreq = (v.mr || v.mw) ? v.dw + 1 : 0;
    edwe  = v.mw ? v.dw + 1 : 0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " cycles"}, cyc, v.cyc);
    chk({tag, " rf_we"}, nrf, v.rf);
    chk({tag, " pc_sel"}, 32'(sel), 32'(v.sel));
    chk({tag, " ir_we"}, nir, 1);
    chk({tag, " imem_req"}, nireq, v.iw + 1);
    chk({tag, " dmem_req"}, ndreq, edreq);
    chk({tag, " dmem_we"}, ndwe, edwe);
    @(posedge clk);
    #1;
    exp_instret++;
    chk({tag, " instret"}, instret, exp_instret);
    chk({tag, " state"}, 32'(state), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    exp_instret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    rst = 1'b1; inst = '0;
    reg_write = 0; mem_read = 0; mem_write = 0;
    branch = 0; jal = 0; jalr = 0; branch_taken = 0;
    imem_ack = 0; dmem_ack = 0;

    tbl[0]  = mk(32'h0050_0093,1,0,0,0,0,0,0,0, 0,0,4,1,PCS_PC4);
    tbl[1]  = mk(32'h0000_a083,1,1,0,0,0,0,0,0, 0,2,7,1,PCS_PC4);
    tbl[2]  = mk(32'h0020_8463,0,0,0,1,1,0,0,0, 0,0,3,0,PCS_IMM);
    tbl[3]  = mk(32'h0020_8463,0,0,0,1,0,0,0,0, 0,0,3,0,PCS_PC4);
    tbl[4]  = mk(32'h0000_80e7,1,0,0,0,0,0,1,0, 0,0,4,1,PCS_JALR);
    tbl[5]  = mk(32'h0020_a023,0,0,1,0,0,0,0,0, 0,0,4,0,PCS_PC4);
    tbl[6]  = mk(32'h0080_00ef,1,0,0,0,0,1,0,1, 0,0,4,1,PCS_IMM);
    tbl[7]  = mk(32'h0050_0093,1,0,0,0,0,0,0,0, 3,0,7,1,PCS_PC4);
    tbl[8]  = mk(32'h0020_a023,0,0,1,0,0,0,0,1, 0,1,5,0,PCS_PC4);
    tbl[9]  = mk(32'h0000_000f,0,0,0,0,0,0,0,0, 0,0,3,0,PCS_PC4);
    tbl[10] = mk(32'h0001_20b7,1,0,0,0,0,0,0,0, 0,0,4,1,PCS_PC4);
    tbl[11] = mk(32'h0000_0073,0,0,0,0,0,0,0,1, 0,0,3,0,PCS_PC4);
    tbl[12] = mk(32'h0000_a083,1,1,0,0,0,0,0,1, 1,0,6,1,PCS_PC4);

    @(posedge clk);
    #1;
    chk("rst pc_we", 32'(pc_we), 32'd1);
    chk("rst pc_sel", 32'(pc_sel), 32'(PCS_RST));
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst ir_we", 32'(ir_we), 32'd0);
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst state", 32'(state), 32'd0);
    chk("rst instret", instret, 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst trap", 32'(trap), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) run(tbl[i], i);

    // EBREAK: halt after DECODE, absorbing
    inst = INST_EBREAK;
    reg_write = 0; mem_read = 0; mem_write = 0;
    branch = 0; jal = 0; jalr = 0;
    @(negedge clk);
    imem_ack = 1'b1;
    #1;
    chk("ebreak ir_we", 32'(ir_we), 32'd1);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("ebreak decode", 32'(state), 32'd1);
    @(negedge clk);
    #1;
    chk("ebreak halt state", 32'(state), 32'd5);
    bad = 0;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (halted !== 1'b1 || imem_req || dmem_req ||
          pc_we || rf_we || ir_we || state != 3'd5)
        bad++;
    end
    chk("halt hold bad cycles", bad, 0);
    do_reset();
    chk("halt rst state", 32'(state), 32'd0);
    chk("halt rst halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("halt exit imem_req", 32'(imem_req), 32'd1);
    chk("halt exit instret", instret, 32'd0);
    @(posedge clk);
    #1;

    // Opcode 7'b1111111
`ifdef ILLEGAL_TRAP_EN
    inst = 32'h0000_007f;
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("illegal state", 32'(state), 32'd5);
    chk("illegal trap", 32'(trap), 32'd1);
    chk("illegal halted", 32'(halted), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("trap sticky", 32'(trap), 32'd1);
    do_reset();
    chk("trap cleared", 32'(trap), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
`else
    run(mk(32'h0000_007f,0,0,0,0,0,0,0,0,
           0,0,3,0,PCS_PC4), 13);
    chk("illegal trap off", 32'(trap), 32'd0);
`endif

    // Reset in the middle of a load's MEM phase
    inst = 32'h0000_a083;
    reg_write = 1; mem_read = 1; mem_write = 0;
    branch = 0; jal = 0; jalr = 0;
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midmem dmem_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midmem req dropped", 32'(dmem_req), 32'd0);
    chk("midmem state", 32'(state), 32'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (state != 3'd0 || !imem_req || dmem_req ||
          pc_we || rf_we)
        bad++;
    end
    chk("late ack ignored", bad, 0);
    chk("midmem instret", instret, 32'd0);
    dmem_ack = 1'b0;
    exp_instret = 0;
    run(tbl[0], 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
